// File: rtl/sdm_pkg.sv
// Shared definitions for the sigma-delta quantizer.
// Holds the FSM state enum, the default block parameters, and the dither
// LFSR constants: width, taps, seed and dither magnitude shift.
package sdm_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int unsigned IN_W_DEF   = 16;
  localparam int unsigned LEVELS_DEF = 16;
  localparam int unsigned OSR_DEF    = 64;
  localparam int unsigned WIDTH_DEF  = 5;

  // x^15 + x^14 + 1, Fibonacci form: feedback from bits 14 and 13
  localparam int unsigned        LFSR_W    = 15;
  localparam logic [LFSR_W-1:0]  LFSR_TAPS = 15'h6000;
  localparam logic [LFSR_W-1:0]  LFSR_SEED = 15'h0001;

  // Dither magnitude is 2^(IN_W - DITHER_SHIFT)
  localparam int unsigned DITHER_SHIFT = 4;

endpackage

// File: rtl/sdm_lfsr.sv
// Dither source: 15-bit maximal-length LFSR that steps once per enabled cycle.
// Ports:
//   clk_i        clock, rising edge
//   reset_i      asynchronous active-high reset, reloads the seed
//   en_i         advance the register this cycle
//   dither_bit_o current dither bit (register MSB)
module sdm_lfsr
  import sdm_pkg::*;
(
  input  logic clk_i,
  input  logic reset_i,
  input  logic en_i,
  output logic dither_bit_o
);

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;

  // Next-state: shift left, feedback is the XOR of the tapped bits
  always_comb begin
    lfsr_d = lfsr_q;
    if (en_i) begin
      lfsr_d = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_TAPS)};
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign dither_bit_o = lfsr_q[LFSR_W-1];

endmodule

// File: rtl/sdm_quantizer.sv
// Second-order error-feedback multi-level quantizer for a sigma-delta DAC.
// Each accepted PCM sample is held for OSR clocks; one code in 0..LEVELS is
// produced per clock while running.
// Optional build macro: SDM_DITHER_EN adds +/-2^(IN_W-4) LFSR dither to the loop.
// Ports:
//   clk_i, reset_i      clock (rising edge), asynchronous active-high reset
//   pcm_data_i          signed PCM sample
//   pcm_valid_i/ready_o sample handshake (accept when both high at an edge)
//   quantized_value_o   unsigned output code, LEVELS/2 while idle
//   out_valid_o         a new code is present this cycle
//   overload_o          sticky: the code or the error was clamped at least once
module sdm_quantizer
  import sdm_pkg::*;
#(
  parameter int unsigned IN_W   = IN_W_DEF,
  parameter int unsigned LEVELS = LEVELS_DEF,
  parameter int unsigned OSR    = OSR_DEF,
  parameter int unsigned WIDTH  = WIDTH_DEF
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic signed [IN_W-1:0] pcm_data_i,
  input  logic                   pcm_valid_i,
  output logic                   pcm_ready_o,
  output logic [WIDTH-1:0]       quantized_value_o,
  output logic                   out_valid_o,
  output logic                   overload_o
);

  localparam int unsigned ACC_W = IN_W + $clog2(LEVELS) + 3;
  localparam int unsigned CNT_W = $clog2(OSR);

  localparam logic signed [ACC_W-1:0] ONE_C  = ACC_W'(64'sd1 <<< IN_W);
  localparam logic signed [ACC_W-1:0] HALF_C = ACC_W'(64'sd1 <<< (IN_W - 1));
  localparam logic signed [ACC_W-1:0] LEV_C  = ACC_W'(LEVELS);
  localparam logic [WIDTH-1:0]        MID_C  = WIDTH'(LEVELS / 2);
  localparam logic [CNT_W-1:0]        LAST_C = CNT_W'(OSR - 1);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic signed [IN_W-1:0]  sample_q, sample_d;
  logic signed [ACC_W-1:0] e1_q, e1_d, e2_q, e2_d;
  logic [WIDTH-1:0]        quant_q, quant_d;
  logic                    valid_q, valid_d;
  logic                    ready_q, ready_d;
  logic                    ovf_q, ovf_d;

  logic                    accept_c;
  logic [IN_W-1:0]         u_c;
  logic signed [ACC_W-1:0] s_c, w_c, dith_c, y_raw_c, y_c, e_raw_c, e_c;
  logic                    clamp_c;

`ifdef SDM_DITHER_EN
  localparam logic signed [ACC_W-1:0] DITH_C = ACC_W'(64'sd1 <<< (IN_W - DITHER_SHIFT));
  logic dither_bit;

  sdm_lfsr u_lfsr (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .en_i         (state_q == RUN),
    .dither_bit_o (dither_bit)
  );

  assign dith_c = dither_bit ? DITH_C : -DITH_C;
`else
  assign dith_c = '0;
`endif

  assign accept_c = pcm_valid_i & ready_q;

  // Loop datapath: offset-binary scale, error feedback, round, clamp
  always_comb begin
    u_c     = {~sample_q[IN_W-1], sample_q[IN_W-2:0]};
    s_c     = signed'(ACC_W'(u_c)) * LEV_C;
    w_c     = s_c + (e1_q <<< 1) - e2_q + dith_c;
    // Arithmetic shift is a floor, so adding half first rounds to nearest
    y_raw_c = (w_c + HALF_C) >>> IN_W;
    clamp_c = 1'b0;
    y_c     = y_raw_c;
    if (y_raw_c[ACC_W-1]) begin
      y_c     = '0;
      clamp_c = 1'b1;
    end else if (y_raw_c > LEV_C) begin
      y_c     = LEV_C;
      clamp_c = 1'b1;
    end
    e_raw_c = w_c - (y_c <<< IN_W);
    e_c     = e_raw_c;
    if (e_raw_c > ONE_C) begin
      e_c     = ONE_C;
      clamp_c = 1'b1;
    end else if (e_raw_c < -ONE_C) begin
      e_c     = -ONE_C;
      clamp_c = 1'b1;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sample_d = sample_q;
    e1_d     = e1_q;
    e2_d     = e2_q;
    quant_d  = MID_C;
    valid_d  = 1'b0;
    ovf_d    = ovf_q;

    case (state_q)
      IDLE: begin
        if (accept_c) begin
          sample_d = pcm_data_i;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        quant_d = WIDTH'(y_c);
        valid_d = 1'b1;
        e2_d    = e1_q;
        e1_d    = e_c;
        ovf_d   = ovf_q | clamp_c;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_C) begin
          cnt_d = '0;
          if (accept_c) begin
            sample_d = pcm_data_i;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Ready is registered from the next state so it is glitch-free
    ready_d = (state_d == IDLE) || (cnt_d == LAST_C);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sample_q <= '0;
      e1_q     <= '0;
      e2_q     <= '0;
      quant_q  <= MID_C;
      valid_q  <= 1'b0;
      ready_q  <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sample_q <= sample_d;
      e1_q     <= e1_d;
      e2_q     <= e2_d;
      quant_q  <= quant_d;
      valid_q  <= valid_d;
      ready_q  <= ready_d;
      ovf_q    <= ovf_d;
    end
  end

  assign pcm_ready_o       = ready_q;
  assign quantized_value_o = quant_q;
  assign out_valid_o       = valid_q;
  assign overload_o        = ovf_q;

endmodule

// File: tb/tb_sdm_quantizer.sv
// Self-checking bench for sdm_quantizer (default build, dither off).
module tb_sdm_quantizer;

  localparam int IN_W   = 16;
  localparam int LEVELS = 16;
  localparam int OSR    = 64;
  localparam int WIDTH  = 5;
  localparam int MID    = LEVELS / 2;

  logic                   clk = 1'b0;
  logic                   reset_i = 1'b1;
  logic signed [IN_W-1:0] pcm_data_i = '0;
  logic                   pcm_valid_i = 1'b0;
  logic                   pcm_ready_o;
  logic [WIDTH-1:0]       quantized_value_o;
  logic                   out_valid_o;
  logic                   overload_o;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  longint m_e1 = 0;
  longint m_e2 = 0;
  bit     m_ovf = 1'b0;
  int     exp_q[$];

  sdm_quantizer #(
    .IN_W   (IN_W),
    .LEVELS (LEVELS),
    .OSR    (OSR),
    .WIDTH  (WIDTH)
  ) dut (
    .clk_i             (clk),
    .reset_i           (reset_i),
    .pcm_data_i        (pcm_data_i),
    .pcm_valid_i       (pcm_valid_i),
    .pcm_ready_o       (pcm_ready_o),
    .quantized_value_o (quantized_value_o),
    .out_valid_o       (out_valid_o),
    .overload_o        (overload_o)
  );

  always #5 clk = ~clk;

  function automatic longint floor_div(input longint a, input longint b);
    longint q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  // Append the OSR expected codes for one held sample and advance the loop
  function automatic void model_sample(input int pcm);
    longint s, w, y, e;
    longint one;
    one = longint'(1) << IN_W;
    s = (longint'(pcm) + (one / 2)) * LEVELS;
    for (int k = 0; k < OSR; k++) begin
      w = s + 2 * m_e1 - m_e2;
      y = floor_div(w + one / 2, one);
      if (y < 0)      begin y = 0;      m_ovf = 1'b1; end
      if (y > LEVELS) begin y = LEVELS; m_ovf = 1'b1; end
      e = w - y * one;
      if (e > one)  begin e = one;  m_ovf = 1'b1; end
      if (e < -one) begin e = -one; m_ovf = 1'b1; end
      m_e2 = m_e1;
      m_e1 = e;
      exp_q.push_back(int'(y));
    end
  endfunction

  function automatic void model_reset();
    m_e1 = 0;
    m_e2 = 0;
    m_ovf = 1'b0;
    exp_q.delete();
  endfunction

  // Feed samples with pcm_valid_i held high; check every code, gaps and ready
  task automatic stream(input int samples[$], output int codes[$]);
    int  n, idx, acc, got, exp_v;
    bit  pend, started, ready_exp;
    n = samples.size();
    idx = 0; acc = 0; got = 0; started = 1'b0;
    codes.delete();
    foreach (samples[i]) model_sample(samples[i]);
    @(negedge clk);
    pcm_valid_i = 1'b1;
    pcm_data_i  = 16'(samples[0]);
    pend = pcm_ready_o;
    for (int cyc = 0; cyc < n * OSR + 16 && got < n * OSR; cyc++) begin
      @(negedge clk);
      if (pend) acc++;
      if (started) begin
        checks++;
        if (out_valid_o !== 1'b1) begin
          failures++;
          $display("FAIL stream_gap: out_valid_o=%0b required 1 after %0d codes", out_valid_o, got);
        end
      end
      if (out_valid_o === 1'b1) begin
        started = 1'b1;
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        checks++;
        if (quantized_value_o !== WIDTH'(exp_v)) begin
          failures++;
          $display("FAIL stream_code[%0d]: got %0d required %0d", got, quantized_value_o, exp_v);
        end
        codes.push_back(int'(quantized_value_o));
        got++;
      end
      ready_exp = (got == acc * OSR) || (got % OSR == OSR - 1);
      checks++;
      if (pcm_ready_o !== ready_exp) begin
        failures++;
        $display("FAIL stream_ready after %0d codes: got %0b required %0b", got, pcm_ready_o, ready_exp);
      end
      if (pend) begin
        idx++;
        if (idx < n) pcm_data_i = 16'(samples[idx]);
        else pcm_valid_i = 1'b0;
      end
      pend = pcm_valid_i && pcm_ready_o;
    end
    pcm_valid_i = 1'b0;
    checks++;
    if (got != n * OSR) begin
      failures++;
      $display("FAIL stream_count: got %0d codes required %0d", got, n * OSR);
    end
    // One cycle after the last code the block must be idle
    @(negedge clk);
    checks++;
    if (out_valid_o !== 1'b0 || quantized_value_o !== WIDTH'(MID) || pcm_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL stream_idle: valid=%0b code=%0d ready=%0b required 0/%0d/1",
               out_valid_o, quantized_value_o, pcm_ready_o, MID);
    end
    checks++;
    if (overload_o !== m_ovf) begin
      failures++;
      $display("FAIL stream_overload: got %0b required %0b", overload_o, m_ovf);
    end
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (pcm_ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready: got %0b required 1", pcm_ready_o); end
    checks++;
    if (out_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid: got %0b required 0", out_valid_o); end
    checks++;
    if (quantized_value_o !== WIDTH'(MID)) begin failures++; $display("FAIL reset_code: got %0d required %0d", quantized_value_o, MID); end
    checks++;
    if (overload_o !== 1'b0) begin failures++; $display("FAIL reset_overload: got %0b required 0", overload_o); end
    model_reset();
    reset_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_midscale();
    int s[$];
    int c[$];
    s.push_back(0);
    stream(s, c);
    foreach (c[i]) begin
      checks++;
      if (c[i] != MID) begin failures++; $display("FAIL midscale[%0d]: got %0d required %0d", i, c[i], MID); end
    end
  endtask

  task automatic test_levels();
    int s[$];
    int c[$];
    int sum;
    s.delete(); s.push_back(-32768);
    stream(s, c);
    foreach (c[i]) begin
      checks++;
      if (c[i] != 0) begin failures++; $display("FAIL level_min[%0d]: got %0d required 0", i, c[i]); end
    end
    s.delete(); s.push_back(16384);
    stream(s, c);
    foreach (c[i]) begin
      checks++;
      if (c[i] != 12) begin failures++; $display("FAIL level_3q[%0d]: got %0d required 12", i, c[i]); end
    end
    s.delete(); s.push_back(-30720);
    stream(s, c);
    sum = 0;
    foreach (c[i]) begin
      sum += c[i];
      checks++;
      if (c[i] > 1) begin failures++; $display("FAIL level_half[%0d]: got %0d required 0 or 1", i, c[i]); end
    end
    checks++;
    if (sum < 31 || sum > 33) begin failures++; $display("FAIL level_half_sum: got %0d required 32+/-1", sum); end
    checks++;
    if (overload_o !== 1'b0) begin failures++; $display("FAIL level_overload: got %0b required 0", overload_o); end
  endtask

  task automatic test_back_to_back();
    int s[$];
    int c[$];
    for (int i = 0; i < 3; i++) s.push_back(int'($urandom_range(65535)) - 32768);
    stream(s, c);
    checks++;
    if (c.size() != 3 * OSR) begin failures++; $display("FAIL b2b_len: got %0d required %0d", c.size(), 3 * OSR); end
  endtask

  task automatic test_overload();
    int s[$];
    int c[$];
    s.push_back(-32767);
    s.push_back(32767);
    s.push_back(int'($urandom_range(65535)) - 32768);
    s.push_back(-32767);
    stream(s, c);
  endtask

  task automatic test_reset_midrun();
    int s[$];
    int c[$];
    int got;
    int exp_v;
    model_sample(0);
    @(negedge clk);
    pcm_valid_i = 1'b1;
    pcm_data_i  = '0;
    @(negedge clk);
    pcm_valid_i = 1'b0;
    got = 0;
    for (int cyc = 0; cyc < 100 && got < 20; cyc++) begin
      @(negedge clk);
      if (out_valid_o === 1'b1) begin
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        checks++;
        if (quantized_value_o !== WIDTH'(exp_v)) begin
          failures++;
          $display("FAIL midrun_code[%0d]: got %0d required %0d", got, quantized_value_o, exp_v);
        end
        got++;
      end
    end
    checks++;
    if (got != 20) begin failures++; $display("FAIL midrun_count: got %0d codes required 20", got); end
    reset_i = 1'b1;
    #1;
    checks++;
    if (pcm_ready_o !== 1'b1 || out_valid_o !== 1'b0 || quantized_value_o !== WIDTH'(MID) || overload_o !== 1'b0) begin
      failures++;
      $display("FAIL midrun_reset: ready=%0b valid=%0b code=%0d ovf=%0b required 1/0/%0d/0",
               pcm_ready_o, out_valid_o, quantized_value_o, overload_o, MID);
    end
    model_reset();
    @(negedge clk);
    reset_i = 1'b0;
    @(negedge clk);
    s.push_back(0);
    stream(s, c);
    foreach (c[i]) begin
      checks++;
      if (c[i] != MID) begin failures++; $display("FAIL midrun_after[%0d]: got %0d required %0d", i, c[i], MID); end
    end
  endtask

  initial begin
    test_reset();
    test_midscale();
    test_levels();
    test_back_to_back();
    test_overload();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
